// File: rtl/rob_commit_queue.sv
// In-order reorder queue: dual dispatch allocation, dual CDB write-back, dual in-order retire.
// Optional build macro ROB_BYPASS_EN forwards same-cycle CDB writes at head/head+1 into commit.
module rob_commit_queue #(
    parameter int DEPTH  = 16,
    parameter int IDX_W  = $clog2(DEPTH),
    parameter int DATA_W = 32,
    parameter int EXC_W  = 5
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_flush,
    input  logic [1:0]             i_alloc_req,
    input  logic [1:0][4:0]        i_alloc_dest,
    output logic                   o_alloc_ready,
    output logic [1:0][IDX_W-1:0]  o_alloc_index,
    input  logic [1:0]             i_cdb_valid,
    input  logic [1:0][IDX_W-1:0]  i_cdb_index,
    input  logic [1:0][DATA_W-1:0] i_cdb_data,
    input  logic [1:0]             i_cdb_ex,
    input  logic [1:0][EXC_W-1:0]  i_cdb_excode,
    input  logic                   i_commit_stall,
    output logic [1:0]             o_commit_valid,
    output logic [1:0][4:0]        o_commit_dest,
    output logic [1:0][DATA_W-1:0] o_commit_data,
    output logic                   o_commit_ex,
    output logic [EXC_W-1:0]       o_commit_excode,
    output logic [IDX_W:0]         o_count,
    output logic                   o_empty
);

    logic [IDX_W:0]        r_head;
    logic [IDX_W:0]        r_tail;
    logic [DEPTH-1:0]      r_busy;
    logic [DEPTH-1:0]      r_done;
    logic [DEPTH-1:0]      r_ex;
    logic [EXC_W-1:0]      r_excode [DEPTH];
    logic [4:0]            r_dest   [DEPTH];
    logic [DATA_W-1:0]     r_data   [DEPTH];

    logic [IDX_W:0]        w_count;
    logic                  w_alloc_ok;
    logic [1:0]            w_alloc;
    logic [1:0]            w_alloc_n;
    logic [1:0][IDX_W-1:0] w_tail_idx;
    logic [1:0][IDX_W-1:0] w_head_idx;
    logic [1:0]            w_wb_hit;

    logic [1:0]            w_v_busy;
    logic [1:0]            w_v_done;
    logic [1:0]            w_v_ex;
    logic [1:0][DATA_W-1:0] w_v_data;
    logic [1:0][4:0]       w_v_dest;
    logic [EXC_W-1:0]      w_head_code;

    logic                  w_cv0;
    logic                  w_cv1;
    logic                  w_cex;
    logic [1:0]            w_ret;
    logic [1:0]            w_retire_n;

    assign w_count       = r_tail - r_head;
    assign w_alloc_ok    = (w_count <= (IDX_W+1)'(DEPTH - 2));
    // A lone bit1 request has no valid ordering and is dropped with bit0.
    assign w_alloc[0]    = i_alloc_req[0] & w_alloc_ok;
    assign w_alloc[1]    = w_alloc[0] & i_alloc_req[1];
    assign w_alloc_n     = {1'b0, w_alloc[0]} + {1'b0, w_alloc[1]};

    assign w_tail_idx[0] = r_tail[IDX_W-1:0];
    assign w_tail_idx[1] = r_tail[IDX_W-1:0] + IDX_W'(1);
    assign w_head_idx[0] = r_head[IDX_W-1:0];
    assign w_head_idx[1] = r_head[IDX_W-1:0] + IDX_W'(1);

    assign w_wb_hit[0]   = i_cdb_valid[0] & r_busy[i_cdb_index[0]];
    assign w_wb_hit[1]   = i_cdb_valid[1] & r_busy[i_cdb_index[1]];

    always_comb begin
        w_v_busy    = '0;
        w_v_done    = '0;
        w_v_ex      = '0;
        w_v_data    = '0;
        w_v_dest    = '0;
        w_head_code = r_excode[w_head_idx[0]];
        for (int s = 0; s < 2; s++) begin
            w_v_busy[s] = r_busy[w_head_idx[s]];
            w_v_done[s] = r_done[w_head_idx[s]];
            w_v_ex[s]   = r_ex[w_head_idx[s]];
            w_v_data[s] = r_data[w_head_idx[s]];
            w_v_dest[s] = r_dest[w_head_idx[s]];
`ifdef ROB_BYPASS_EN
            // Lane 1 is applied last so it wins on a same-index collision.
            for (int l = 0; l < 2; l++) begin
                if (w_wb_hit[l] && (i_cdb_index[l] == w_head_idx[s])) begin
                    w_v_done[s] = 1'b1;
                    w_v_ex[s]   = i_cdb_ex[l];
                    w_v_data[s] = i_cdb_data[l];
                    if (s == 0) begin
                        w_head_code = i_cdb_excode[l];
                    end
                end
            end
`endif
        end
    end

    assign w_cv0      = ~i_commit_stall & w_v_busy[0] & w_v_done[0] & ~w_v_ex[0];
    assign w_cv1      = w_cv0 & w_v_busy[1] & w_v_done[1] & ~w_v_ex[1];
    assign w_cex      = ~i_commit_stall & w_v_busy[0] & w_v_done[0] & w_v_ex[0];
    assign w_ret[0]   = w_cv0 | w_cex;
    assign w_ret[1]   = w_cv1;
    assign w_retire_n = {1'b0, w_ret[0]} + {1'b0, w_ret[1]};

    assign o_alloc_ready    = w_alloc_ok;
    assign o_alloc_index    = w_tail_idx;
    assign o_count          = w_count;
    assign o_empty          = (w_count == '0);
    assign o_commit_valid   = {w_cv1, w_cv0};
    assign o_commit_ex      = w_cex;
    assign o_commit_excode  = w_cex ? w_head_code : '0;
    assign o_commit_dest[0] = w_cv0 ? w_v_dest[0] : '0;
    assign o_commit_dest[1] = w_cv1 ? w_v_dest[1] : '0;
    assign o_commit_data[0] = w_cv0 ? w_v_data[0] : '0;
    assign o_commit_data[1] = w_cv1 ? w_v_data[1] : '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_head <= '0;
            r_tail <= '0;
        end else if (i_flush) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            r_head <= r_head + (IDX_W+1)'(w_retire_n);
            r_tail <= r_tail + (IDX_W+1)'(w_alloc_n);
        end
    end

    // Retirement is applied last; allocated slots are never busy, so no overlap with it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy <= '0;
            r_done <= '0;
            r_ex   <= '0;
        end else if (i_flush) begin
            r_busy <= '0;
            r_done <= '0;
            r_ex   <= '0;
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                for (int a = 0; a < 2; a++) begin
                    if (w_alloc[a] && (w_tail_idx[a] == IDX_W'(e))) begin
                        r_busy[e] <= 1'b1;
                        r_done[e] <= 1'b0;
                        r_ex[e]   <= 1'b0;
                    end
                end
                for (int l = 0; l < 2; l++) begin
                    if (w_wb_hit[l] && (i_cdb_index[l] == IDX_W'(e))) begin
                        r_done[e] <= 1'b1;
                        r_ex[e]   <= i_cdb_ex[l];
                    end
                end
                for (int s = 0; s < 2; s++) begin
                    if (w_ret[s] && (w_head_idx[s] == IDX_W'(e))) begin
                        r_busy[e] <= 1'b0;
                        r_done[e] <= 1'b0;
                        r_ex[e]   <= 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        for (int e = 0; e < DEPTH; e++) begin
            for (int a = 0; a < 2; a++) begin
                if (w_alloc[a] && (w_tail_idx[a] == IDX_W'(e))) begin
                    r_dest[e] <= i_alloc_dest[a];
                end
            end
            for (int l = 0; l < 2; l++) begin
                if (w_wb_hit[l] && (i_cdb_index[l] == IDX_W'(e))) begin
                    r_data[e]   <= i_cdb_data[l];
                    r_excode[e] <= i_cdb_excode[l];
                end
            end
        end
    end

endmodule

// File: tb/tb_rob_commit_queue.sv
// Directed bench for rob_commit_queue: in-order scoreboard of allocated indices,
// popped and compared whenever the queue retires an entry.
module tb_rob_commit_queue;

    localparam int DEPTH  = 16;
    localparam int IDX_W  = 4;
    localparam int DATA_W = 32;
    localparam int EXC_W  = 5;

    logic                   clk;
    logic                   rst_n;
    logic                   flush;
    logic [1:0]             alloc_req;
    logic [1:0][4:0]        alloc_dest;
    logic                   alloc_ready;
    logic [1:0][IDX_W-1:0]  alloc_index;
    logic [1:0]             cdb_valid;
    logic [1:0][IDX_W-1:0]  cdb_index;
    logic [1:0][DATA_W-1:0] cdb_data;
    logic [1:0]             cdb_ex;
    logic [1:0][EXC_W-1:0]  cdb_excode;
    logic                   commit_stall;
    logic [1:0]             commit_valid;
    logic [1:0][4:0]        commit_dest;
    logic [1:0][DATA_W-1:0] commit_data;
    logic                   commit_ex;
    logic [EXC_W-1:0]       commit_excode;
    logic [IDX_W:0]         count;
    logic                   empty;

    int n_tests = 0;
    int n_fail  = 0;

    int               q[$];
    logic [4:0]       sb_dest [DEPTH];
    logic [31:0]      sb_data [DEPTH];
    bit               sb_ex   [DEPTH];
    logic [4:0]       sb_code [DEPTH];
    int               tb_tail = 0;

    rob_commit_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .EXC_W(EXC_W)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
        .i_alloc_req(alloc_req), .i_alloc_dest(alloc_dest),
        .o_alloc_ready(alloc_ready), .o_alloc_index(alloc_index),
        .i_cdb_valid(cdb_valid), .i_cdb_index(cdb_index), .i_cdb_data(cdb_data),
        .i_cdb_ex(cdb_ex), .i_cdb_excode(cdb_excode),
        .i_commit_stall(commit_stall),
        .o_commit_valid(commit_valid), .o_commit_dest(commit_dest),
        .o_commit_data(commit_data), .o_commit_ex(commit_ex),
        .o_commit_excode(commit_excode), .o_count(count), .o_empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sb_check();
        int idx;
        if (commit_ex) begin
            chk("sb_ex_pending", 32'(q.size() > 0), 1);
            if (q.size() > 0) begin
                idx = q.pop_front();
                chk("commit_ex_flag", 32'(sb_ex[idx]), 1);
                chk("commit_excode", 32'(commit_excode), 32'(sb_code[idx]));
                chk("ex_no_valid", 32'(commit_valid), 0);
            end
        end
        for (int s = 0; s < 2; s++) begin
            if (commit_valid[s]) begin
                chk("sb_commit_pending", 32'(q.size() > 0), 1);
                if (q.size() > 0) begin
                    idx = q.pop_front();
                    chk("commit_dest", 32'(commit_dest[s]), 32'(sb_dest[idx]));
                    chk("commit_data", commit_data[s], sb_data[idx]);
                    chk("commit_not_ex", 32'(sb_ex[idx]), 0);
                end
            end
        end
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic tick(input bit do_sb);
        #1;
        if (do_sb) sb_check();
        @(posedge clk);
        #1;
        alloc_req = '0;
        cdb_valid = '0;
        cdb_ex    = '0;
        flush     = 1'b0;
    endtask

    task automatic drive_alloc(input logic [1:0] req, input bit push);
        int idx;
        alloc_req = req;
        for (int k = 0; k < 2; k++) begin
            idx = (tb_tail + k) % DEPTH;
            alloc_dest[k] = 5'((idx * 7 + 3) % 32);
        end
        if (push) begin
            for (int k = 0; k < 2; k++) begin
                if (req[k]) begin
                    idx = tb_tail % DEPTH;
                    sb_dest[idx] = alloc_dest[k];
                    sb_ex[idx]   = 1'b0;
                    q.push_back(idx);
                    tb_tail++;
                end
            end
        end
    endtask

    task automatic drive_cdb(input int lane, input int idx, input logic [31:0] data,
                             input bit ex, input logic [4:0] code);
        cdb_valid[lane]  = 1'b1;
        cdb_index[lane]  = IDX_W'(idx);
        cdb_data[lane]   = data;
        cdb_ex[lane]     = ex;
        cdb_excode[lane] = code;
        sb_data[idx] = data;
        sb_ex[idx]   = ex;
        sb_code[idx] = code;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick(0);
        q.delete();
        tb_tail = 0;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; alloc_req = '0; alloc_dest = '0;
        cdb_valid = '0; cdb_index = '0; cdb_data = '0; cdb_ex = '0; cdb_excode = '0;
        commit_stall = 1'b0;

        // reset state
        #3;
        chk("rst_alloc_ready", 32'(alloc_ready), 1);
        chk("rst_alloc_index0", 32'(alloc_index[0]), 0);
        chk("rst_alloc_index1", 32'(alloc_index[1]), 1);
        chk("rst_commit_valid", 32'(commit_valid), 0);
        chk("rst_commit_ex", 32'(commit_ex), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // fill with dual allocation until full
        for (int k = 0; k < 8; k++) begin
            drive_alloc(2'b11, 1'b1);
            settle();
            chk("fill_index0", 32'(alloc_index[0]), 2 * k);
            chk("fill_index1", 32'(alloc_index[1]), 2 * k + 1);
            chk("fill_ready", 32'(alloc_ready), 1);
            chk("fill_count", 32'(count), 2 * k);
            tick(1);
        end
        drive_alloc(2'b11, 1'b0);
        settle();
        chk("full_ready", 32'(alloc_ready), 0);
        chk("full_count", 32'(count), 16);
        tick(1);
        settle();
        chk("full_ignored_count", 32'(count), 16);
        chk("full_not_empty", 32'(empty), 0);
        do_flush();
        settle();
        chk("flush_count", 32'(count), 0);
        chk("flush_empty", 32'(empty), 1);
        chk("flush_index0", 32'(alloc_index[0]), 0);

        // out-of-order completion, in-order retire
        drive_alloc(2'b11, 1'b1); tick(1);
        drive_alloc(2'b11, 1'b1); tick(1);
        drive_cdb(0, 3, $urandom, 1'b0, 5'd0);
        drive_cdb(1, 2, $urandom, 1'b0, 5'd0);
        settle();
        chk("ooo_wait_head", 32'(commit_valid), 0);
        tick(1);
        commit_stall = 1'b1;
        drive_cdb(0, 1, $urandom, 1'b0, 5'd0);
        drive_cdb(1, 0, $urandom, 1'b0, 5'd0);
        settle();
        chk("ooo_stalled", 32'(commit_valid), 0);
        tick(1);
        commit_stall = 1'b0;
        settle();
        chk("ooo_commit01", 32'(commit_valid), 3);
        tick(1);
        settle();
        chk("ooo_commit23", 32'(commit_valid), 3);
        tick(1);
        settle();
        chk("ooo_empty", 32'(empty), 1);
        chk("ooo_idle", 32'(commit_valid), 0);
        do_flush();

        // precise exception at head
        drive_alloc(2'b11, 1'b1); tick(1);
        commit_stall = 1'b1;
        drive_cdb(0, 0, $urandom, 1'b1, 5'd4);
        drive_cdb(1, 1, $urandom, 1'b0, 5'd0);
        tick(1);
        commit_stall = 1'b0;
        settle();
        chk("exc_flag", 32'(commit_ex), 1);
        chk("exc_code", 32'(commit_excode), 4);
        chk("exc_valid", 32'(commit_valid), 0);
        tick(1);
        settle();
        chk("exc_count_after", 32'(count), 1);
        chk("exc_cleared", 32'(commit_ex), 0);
        do_flush();
        settle();
        chk("exc_flush_count", 32'(count), 0);

        // both lanes hit the same index, lane 1 wins
        drive_alloc(2'b11, 1'b1); tick(1);
        drive_alloc(2'b11, 1'b1); tick(1);
        commit_stall = 1'b1;
        drive_cdb(0, 0, $urandom, 1'b0, 5'd0);
        drive_cdb(1, 1, $urandom, 1'b0, 5'd0);
        tick(1);
        drive_cdb(0, 2, 32'h0000_AAAA, 1'b0, 5'd0);
        drive_cdb(1, 2, 32'h0000_5555, 1'b0, 5'd0);
        tick(1);
        drive_cdb(0, 3, $urandom, 1'b0, 5'd0);
        tick(1);
        commit_stall = 1'b0;
        settle();
        chk("dup_commit01", 32'(commit_valid), 3);
        tick(1);
        settle();
        chk("dup_commit23", 32'(commit_valid), 3);
        chk("dup_lane1_wins", commit_data[0], 32'h0000_5555);
        tick(1);
        do_flush();

        // pointer wrap with simultaneous alloc and commit
        for (int k = 0; k < 7; k++) begin
            drive_alloc(2'b11, 1'b1); tick(1);
        end
        for (int k = 0; k < 7; k++) begin
            drive_cdb(0, 2 * k, $urandom, 1'b0, 5'd0);
            drive_cdb(1, 2 * k + 1, $urandom, 1'b0, 5'd0);
            tick(1);
        end
        tick(1);
        settle();
        chk("wrap_drained", 32'(count), 0);
        chk("wrap_tail14", 32'(alloc_index[0]), 14);
        drive_alloc(2'b11, 1'b1);
        settle();
        chk("wrap_idx15", 32'(alloc_index[1]), 15);
        tick(1);
        drive_alloc(2'b11, 1'b1);
        settle();
        chk("wrap_idx0", 32'(alloc_index[0]), 0);
        chk("wrap_idx1", 32'(alloc_index[1]), 1);
        tick(1);
        settle();
        chk("wrap_count4", 32'(count), 4);
        commit_stall = 1'b1;
        drive_cdb(0, 14, $urandom, 1'b0, 5'd0);
        drive_cdb(1, 15, $urandom, 1'b0, 5'd0);
        tick(1);
        commit_stall = 1'b0;
        drive_alloc(2'b11, 1'b1);
        settle();
        chk("wrap_commit2", 32'(commit_valid), 3);
        chk("wrap_alloc_idx2", 32'(alloc_index[0]), 2);
        chk("wrap_ready", 32'(alloc_ready), 1);
        tick(1);
        settle();
        chk("wrap_net_count", 32'(count), 4);
        chk("wrap_tail_idx4", 32'(alloc_index[0]), 4);
        drive_cdb(0, 0, $urandom, 1'b0, 5'd0);
        drive_cdb(1, 1, $urandom, 1'b0, 5'd0);
        tick(1);
        drive_cdb(0, 2, $urandom, 1'b0, 5'd0);
        drive_cdb(1, 3, $urandom, 1'b0, 5'd0);
        tick(1);
        tick(1);
        settle();
        chk("wrap_final_empty", 32'(empty), 1);
        do_flush();

        // commit stall holds the head
        drive_alloc(2'b11, 1'b1); tick(1);
        commit_stall = 1'b1;
        drive_cdb(0, 0, $urandom, 1'b0, 5'd0);
        drive_cdb(1, 1, $urandom, 1'b0, 5'd0);
        settle();
        chk("stall_wr_cycle", 32'(commit_valid), 0);
        tick(1);
        settle();
        chk("stall_held", 32'(commit_valid), 0);
        chk("stall_count", 32'(count), 2);
        tick(1);
        commit_stall = 1'b0;
        settle();
        chk("stall_release", 32'(commit_valid), 3);
        tick(1);

        // write-to-commit latency at head
        drive_alloc(2'b11, 1'b1); tick(1);
        drive_cdb(0, 2, $urandom, 1'b0, 5'd0);
        settle();
`ifdef ROB_BYPASS_EN
        chk("bypass_same_cycle", 32'(commit_valid), 1);
        tick(1);
`else
        chk("nobypass_same_cycle", 32'(commit_valid), 0);
        tick(1);
        settle();
        chk("nobypass_next_cycle", 32'(commit_valid), 1);
        tick(1);
`endif
        drive_cdb(0, 3, $urandom, 1'b0, 5'd0);
        tick(1);
        tick(1);
        settle();
        chk("end_empty", 32'(empty), 1);
        chk("end_sb_drained", 32'(q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
